// File: rtl/hazard_stall_ctrl.sv
// ID/EX boundary sequencing: load-use bubbles, redirect flushes, MDU start/done
// handshake with timeout abort, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_write_en,
    input  logic             ex_mem_read,
    input  logic             ex_is_muldiv,
    input  logic             ex_redirect,
    input  logic             mdu_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_bubble,
    output logic             mdu_start,
    output logic             mdu_abort,
    output logic             mdu_error,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MDU_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       mdu_cnt;
    logic [7:0]       mdu_cnt_nxt;
    logic             error_q;
    logic             lu;
    logic             timeout;

    always_comb begin
        lu = ex_mem_read && ex_write_en && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
              (id_uses_rs2 && (id_rs2 == ex_rd)));
        timeout = (mdu_cnt == TIMEOUT_VAL);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        case (state)
            RUN: begin
                if (!ex_redirect && ex_is_muldiv) begin
                    state_nxt   = MDU_BUSY;
                    mdu_cnt_nxt = 8'd1;
                end
            end
            MDU_BUSY: begin
                // done takes priority over a coincident timeout
                if (mdu_done || timeout) begin
                    state_nxt = RUN;
                end else begin
                    mdu_cnt_nxt = mdu_cnt + 8'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_bubble = 1'b0;
        mdu_start   = 1'b0;
        mdu_abort   = 1'b0;
        if (Reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (ex_is_muldiv) begin
                        mdu_start  = 1'b1;
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                    end else if (lu) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_done) begin
                        pc_stall = 1'b0;
                    end else if (timeout) begin
                        mdu_abort   = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                    end
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else if (mdu_abort) begin
            error_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (pc_stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    always_comb begin
        mdu_error  = Reset ? 1'b0 : error_q;
        busy_state = state;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one table of single-cycle RUN vectors
// plus hand-written MDU handshake, timeout, reset and counter-saturation sequences.
module tb_hazard_stall_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_write_en, ex_mem_read;
    logic       ex_is_muldiv, ex_redirect, mdu_done;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
    logic       mdu_start, mdu_abort, mdu_error;
    logic [1:0] busy_state;
    logic [7:0] stall_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_cnt  = 8'd0;

    hazard_stall_ctrl #(.MDU_TIMEOUT(8), .CNT_W(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_write_en(ex_write_en), .ex_mem_read(ex_mem_read),
        .ex_is_muldiv(ex_is_muldiv), .ex_redirect(ex_redirect), .mdu_done(mdu_done),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_bubble(idex_bubble),
        .mdu_start(mdu_start), .mdu_abort(mdu_abort), .mdu_error(mdu_error),
        .busy_state(busy_state), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // Expected output word: {pc, ifid_stall, ifid_flush, idex_stall, idex_bubble,
    //                        mdu_start, mdu_abort, mdu_error, busy_state[1:0]}
    localparam logic [9:0] IDLE  = 10'b0000000000;
    localparam logic [9:0] LU    = 10'b1100100000;
    localparam logic [9:0] REDIR = 10'b0010100000;
    localparam logic [9:0] RST_R = 10'b0010100000;
    localparam logic [9:0] RST_B = 10'b0010100001;
    localparam logic [9:0] START = 10'b1101010000;
    localparam logic [9:0] BUSY  = 10'b1101000001;
    localparam logic [9:0] DONE  = 10'b0000000001;
    localparam logic [9:0] ABORT = 10'b0000101001;
    localparam logic [9:0] E     = 10'b0000000100;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we, mr, md, rdr, dn;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic we, input logic mr, input logic md,
                               input logic rdr, input logic dn, input logic [9:0] exp);
        vec_t t;
        t.rst = rst; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
        t.we = we; t.mr = mr; t.md = md; t.rdr = rdr; t.dn = dn; t.exp = exp;
        return t;
    endfunction

    function automatic vec_t mdu(input logic rst, input logic md, input logic dn,
                                 input logic [9:0] exp);
        return v(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, md, 1'b0, dn, exp);
    endfunction

    // Apply one cycle of inputs, check the Mealy outputs and the counter, then clock.
    task automatic step(input vec_t t, input string name);
        logic [9:0] act;
        Reset = t.rst; id_rs1 = t.rs1; id_rs2 = t.rs2; id_uses_rs1 = t.u1;
        id_uses_rs2 = t.u2; ex_rd = t.rd; ex_write_en = t.we; ex_mem_read = t.mr;
        ex_is_muldiv = t.md; ex_redirect = t.rdr; mdu_done = t.dn;
        #2;
        act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
               mdu_start, mdu_abort, mdu_error, busy_state};
        n_checks++;
        if (act !== t.exp) begin
            n_fail++;
            $display("FAIL %s outputs: got %b expected %b", name, act, t.exp);
        end
        n_checks++;
        if (stall_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s stall_count: got %0d expected %0d", name, stall_count, exp_cnt);
        end
        if (t.rst) exp_cnt = 8'd0;
        else if (t.exp[9] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = v(0, 5'd5,  5'd1,  1, 1, 5'd5,  1, 1, 0, 0, 0, LU);
        tbl[1]  = v(0, 5'd0,  5'd1,  1, 1, 5'd0,  1, 1, 0, 0, 0, IDLE);
        tbl[2]  = v(0, 5'd5,  5'd1,  0, 1, 5'd5,  1, 1, 0, 0, 0, IDLE);
        tbl[3]  = v(0, 5'd1,  5'd7,  1, 1, 5'd7,  1, 1, 0, 0, 0, LU);
        tbl[4]  = v(0, 5'd1,  5'd7,  1, 0, 5'd7,  1, 1, 0, 0, 0, IDLE);
        tbl[5]  = v(0, 5'd5,  5'd1,  1, 1, 5'd5,  1, 0, 0, 0, 0, IDLE);
        tbl[6]  = v(0, 5'd5,  5'd1,  1, 1, 5'd5,  0, 1, 0, 0, 0, IDLE);
        tbl[7]  = v(0, 5'd5,  5'd1,  1, 1, 5'd5,  1, 1, 0, 1, 0, REDIR);
        tbl[8]  = v(0, 5'd5,  5'd1,  1, 1, 5'd5,  1, 1, 1, 1, 0, REDIR);
        tbl[9]  = v(0, 5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 0, 0, 1, IDLE);
        tbl[10] = v(0, 5'd31, 5'd31, 1, 1, 5'd31, 1, 1, 0, 0, 0, LU);
        tbl[11] = v(0, 5'd3,  5'd4,  1, 1, 5'd2,  1, 1, 0, 0, 0, IDLE);

        // First reset cycle is unchecked: state is unknown until the first edge.
        Reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = '0; ex_write_en = 1'b0; ex_mem_read = 1'b0; ex_is_muldiv = 1'b0;
        ex_redirect = 1'b0; mdu_done = 1'b0;
        @(posedge CLK);
        #1;
        step(mdu(1, 0, 0, RST_R), "reset");
        step(mdu(0, 0, 0, IDLE),  "post_reset");

        for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

        // mul: done on the 5th BUSY cycle, then a back-to-back div that times out
        step(mdu(0, 1, 0, START), "mul_start");
        for (int i = 1; i <= 4; i++) step(mdu(0, 1, 0, BUSY), $sformatf("mul_busy%0d", i));
        step(mdu(0, 1, 1, DONE), "mul_done");
        step(mdu(0, 1, 0, START), "div_start");
        for (int i = 1; i <= 7; i++) step(mdu(0, 1, 0, BUSY), $sformatf("div_busy%0d", i));
        step(mdu(0, 1, 0, ABORT), "div_abort");
        step(mdu(0, 0, 0, IDLE | E), "after_abort");
        step(mdu(0, 0, 0, IDLE | E), "error_sticky");

        // done coincident with timeout: done wins
        step(mdu(0, 1, 0, START | E), "div2_start");
        for (int i = 1; i <= 7; i++) step(mdu(0, 1, 0, BUSY | E), $sformatf("div2_busy%0d", i));
        step(mdu(0, 1, 1, DONE | E), "div2_done_at_timeout");
        step(mdu(0, 0, 0, IDLE | E), "div2_after");

        // reset while BUSY: back to RUN, no abort, no start, error cleared
        step(mdu(0, 1, 0, START | E), "div3_start");
        step(mdu(0, 1, 0, BUSY | E), "div3_busy1");
        step(mdu(0, 1, 0, BUSY | E), "div3_busy2");
        step(mdu(1, 1, 0, RST_B), "reset_in_busy");
        step(mdu(0, 0, 0, IDLE), "after_busy_reset");

        // saturate the 8-bit stall counter with continuous load-use stalls
        for (int i = 0; i < 260; i++) step(tbl[0], "saturate");
        step(mdu(0, 0, 0, IDLE), "saturated");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
